// File: rtl/usb_pkg.sv
// Shared types and constants for the full-speed receive front-end.
// Line-state codes match the synchronized {dp,dn} pair.
package usb_pkg;

    localparam int USB_OVERSAMPLE     = 4;
    localparam int USB_SAMPLE_PHASE   = 2;
    localparam int USB_SYNC_MIN_ZEROS = 5;
    localparam int USB_STUFF_LEN      = 6;

    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_K   = 2'b01,
        LS_J   = 2'b10,
        LS_SE1 = 2'b11
    } line_state_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP,
        ST_ABORT
    } rx_state_t;

endpackage

// File: rtl/usb_fe_rx_if.sv
// Pin/byte bundle between the bus driver and the receive front-end.
// slave = front-end side, master = the side driving the raw lines.
interface usb_fe_rx_if;
    import usb_pkg::*;

    logic        dp;
    logic        dn;
    line_state_t line_state;
    logic        rx_active;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_eop;
    logic        rx_err;

    modport master (
        output dp, dn,
        input  line_state, rx_active, rx_valid, rx_data, rx_eop, rx_err
    );

    modport slave (
        input  dp, dn,
        output line_state, rx_active, rx_valid, rx_data, rx_eop, rx_err
    );

endinterface

// File: rtl/usb_fe_dpll.sv
// Line synchronizers and oversampling phase tracker.
// Emits one bit strobe per USB bit, re-centred on every line transition.
module usb_fe_dpll
    import usb_pkg::*;
#(
    parameter int OVERSAMPLE   = USB_OVERSAMPLE,
    parameter int SAMPLE_PHASE = USB_SAMPLE_PHASE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_dp,
    input  logic        i_dn,
    output line_state_t o_line_state,
    output logic        o_bit_stb
);

    localparam int PW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);
    localparam logic [PW-1:0] PH_SAMP = PW'(SAMPLE_PHASE);

    logic [1:0]    r_s1;
    logic [1:0]    r_s2;
    logic [PW-1:0] r_phase;

    // Two-stage synchronizer for {dp,dn}; idles at J
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 2'b10;
            r_s2 <= 2'b10;
        end else begin
            r_s1 <= {i_dp, i_dn};
            r_s2 <= r_s1;
        end
    end

    // Phase counter: zero on the first cycle a new line value is visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_phase <= '0;
        else if (r_s1 != r_s2)
            r_phase <= '0;
        else if (r_phase == PH_LAST)
            r_phase <= '0;
        else
            r_phase <= r_phase + 1'b1;
    end

    assign o_line_state = line_state_t'(r_s2);
    assign o_bit_stb    = (r_phase == PH_SAMP);

endmodule

// File: rtl/usb_fe_rx.sv
// Full-speed receive front-end: NRZI decode, unstuff, SYNC/EOP
// detection and byte assembly on top of the oversampling DPLL.
module usb_fe_rx
    import usb_pkg::*;
#(
    parameter int OVERSAMPLE     = USB_OVERSAMPLE,
    parameter int SAMPLE_PHASE   = USB_SAMPLE_PHASE,
    parameter int SYNC_MIN_ZEROS = USB_SYNC_MIN_ZEROS
) (
    input  logic       clk,
    input  logic       rst_n,
    usb_fe_rx_if.slave bus
);

    localparam logic [2:0] ZMIN  = 3'(SYNC_MIN_ZEROS);
    localparam logic [2:0] STUFF = 3'(USB_STUFF_LEN);

    line_state_t w_ls;
    logic        w_stb;
    logic        w_jk;
    logic        w_dec;

    rx_state_t   r_state;
    line_state_t r_prev;
    logic [2:0]  r_zeros;
    logic [2:0]  r_ones;
    logic [2:0]  r_bitcnt;
    logic [6:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_active;
    logic        r_valid;
    logic        r_eop;
    logic        r_err;
    logic        r_partial;
    logic        r_jseen;

    usb_fe_dpll #(
        .OVERSAMPLE   (OVERSAMPLE),
        .SAMPLE_PHASE (SAMPLE_PHASE)
    ) u_dpll (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_dp         (bus.dp),
        .i_dn         (bus.dn),
        .o_line_state (w_ls),
        .o_bit_stb    (w_stb)
    );

    assign w_jk  = (w_ls == LS_J) || (w_ls == LS_K);
    assign w_dec = (w_ls == r_prev);

    // NRZI history: last sampled J/K level, SE0/SE1 leave it unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_prev <= LS_J;
        else if (w_stb && w_jk)
            r_prev <= w_ls;
    end

    // Receive FSM with unstuffer, byte shifter and registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_zeros   <= '0;
            r_ones    <= '0;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_active  <= 1'b0;
            r_valid   <= 1'b0;
            r_eop     <= 1'b0;
            r_err     <= 1'b0;
            r_partial <= 1'b0;
            r_jseen   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_eop   <= 1'b0;
            r_err   <= 1'b0;
            if (w_stb) begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (w_ls == LS_K) begin
                            r_state <= ST_SYNC;
                            r_zeros <= 3'd1;
                        end
                    end
                    ST_SYNC: begin
                        if (!w_jk) begin
                            r_state <= ST_IDLE;
                        end else if (!w_dec) begin
                            if (r_zeros != 3'd7)
                                r_zeros <= r_zeros + 3'd1;
                        end else if (r_zeros >= ZMIN) begin
                            r_state  <= ST_DATA;
                            r_active <= 1'b1;
                            r_ones   <= 3'd1;
                            r_bitcnt <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        if (w_ls == LS_SE0) begin
                            r_state   <= ST_EOP;
                            r_partial <= (r_bitcnt != 3'd0);
                        end else if (w_ls == LS_SE1 ||
                                     (r_ones == STUFF && w_dec)) begin
                            r_state  <= ST_ABORT;
                            r_err    <= 1'b1;
                            r_active <= 1'b0;
                            r_jseen  <= 1'b0;
                        end else if (r_ones == STUFF) begin
                            r_ones <= '0;
                        end else begin
                            r_ones   <= w_dec ? r_ones + 3'd1 : 3'd0;
                            r_shift  <= {w_dec, r_shift[6:1]};
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                r_data  <= {w_dec, r_shift};
                                r_valid <= 1'b1;
                            end
                        end
                    end
                    ST_EOP: begin
                        if (w_ls == LS_J) begin
                            r_state  <= ST_IDLE;
                            r_eop    <= 1'b1;
                            r_err    <= r_partial;
                            r_active <= 1'b0;
                        end else if (w_ls != LS_SE0) begin
                            r_state  <= ST_ABORT;
                            r_err    <= 1'b1;
                            r_active <= 1'b0;
                            r_jseen  <= 1'b0;
                        end
                    end
                    ST_ABORT: begin
                        if (w_ls == LS_J) begin
                            r_jseen <= 1'b1;
                            if (r_jseen)
                                r_state <= ST_IDLE;
                        end else begin
                            r_jseen <= 1'b0;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.line_state = w_ls;
    assign bus.rx_active  = r_active;
    assign bus.rx_valid   = r_valid;
    assign bus.rx_data    = r_data;
    assign bus.rx_eop     = r_eop;
    assign bus.rx_err     = r_err;

endmodule

// File: tb/tb_usb_fe_rx.sv
// Bench for usb_fe_rx: jittered host driver, packet vector table,
// random payload and mid-packet reset against a bit-level model.
`timescale 1ns/1ps
module tb_usb_fe_rx;
    import usb_pkg::*;

    localparam realtime BIT_NS = 83.333;

    typedef struct {
        logic [127:0] data;
        int           nbits;
        bit           stuff;
        int           exp_bytes;
        int           exp_eop;
        int           exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    usb_fe_rx_if bus ();

    usb_fe_rx dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #10.417 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] got_q[$];
    int         n_eop;
    int         n_err;
    int         n_coinc;
    bit         saw_active;
    bit         abort_tx;
    bit         tx_q[$];
    realtime    t_edge;
    logic [1:0] tx_lvl;
    int         tx_ones;

    // Observe the byte/strobe outputs away from the active edge
    always @(negedge clk) begin
        if (bus.rx_valid) got_q.push_back(bus.rx_data);
        if (bus.rx_eop) n_eop++;
        if (bus.rx_err) n_err++;
        if (bus.rx_active) saw_active = 1'b1;
        if (bus.rx_valid && bus.rx_eop) n_coinc++;
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One line symbol at the next bit edge, with jitter and dp/dn skew
    task automatic put_sym(logic [1:0] s);
        realtime te;
        int      jit;
        int      sk;
        if (abort_tx) return;
        jit = int'($urandom_range(200));
        sk  = int'($urandom_range(200));
        te  = t_edge + (jit - 100) / 1000.0;
        if (te > $realtime) #(te - $realtime);
        if ($urandom_range(1) == 1) begin
            bus.dp = s[1];
            #(sk / 1000.0);
            bus.dn = s[0];
        end else begin
            bus.dn = s[0];
            #(sk / 1000.0);
            bus.dp = s[1];
        end
        t_edge += BIT_NS;
    endtask

    // NRZI-encode one bit; insert a 0 after six 1s when stuffing
    task automatic tx_bit(bit b, bit stuff);
        if (!b) tx_lvl = ~tx_lvl;
        put_sym(tx_lvl);
        tx_ones = b ? tx_ones + 1 : 0;
        if (stuff && tx_ones == 6) begin
            tx_lvl = ~tx_lvl;
            put_sym(tx_lvl);
            tx_ones = 0;
        end
    endtask

    // SYNC, the bits of tx_q in wire order, EOP, then idle J
    task automatic send_pkt(bit stuff);
        tx_lvl  = 2'b10;
        tx_ones = 0;
        t_edge  = $realtime + BIT_NS;
        for (int i = 0; i < 8; i++) tx_bit(i == 7, stuff);
        foreach (tx_q[i]) tx_bit(tx_q[i], stuff);
        put_sym(2'b00);
        put_sym(2'b00);
        for (int i = 0; i < 5; i++) put_sym(2'b10);
    endtask

    task automatic clear_mon();
        got_q.delete();
        n_eop      = 0;
        n_err      = 0;
        n_coinc    = 0;
        saw_active = 1'b0;
    endtask

    task automatic run_vec(vec_t v, string nm);
        clear_mon();
        tx_q.delete();
        for (int i = 0; i < v.nbits; i++) tx_q.push_back(v.data[i]);
        send_pkt(v.stuff);
        repeat (20) @(negedge clk);
        chk({nm, ".nbytes"}, got_q.size(), v.exp_bytes);
        for (int i = 0; i < v.exp_bytes && i < got_q.size(); i++)
            chk({nm, ".byte"}, got_q[i], v.data[8*i +: 8]);
        chk({nm, ".eop"}, n_eop, v.exp_eop);
        chk({nm, ".err"}, n_err, v.exp_err);
        chk({nm, ".active_seen"}, saw_active, 1);
        chk({nm, ".active_end"}, bus.rx_active, 0);
        chk({nm, ".valid_eop_overlap"}, n_coinc, 0);
    endtask

    task automatic chk_reset_vals(string nm);
        chk({nm, ".line_state"}, bus.line_state, LS_J);
        chk({nm, ".rx_active"}, bus.rx_active, 0);
        chk({nm, ".rx_valid"}, bus.rx_valid, 0);
        chk({nm, ".rx_data"}, bus.rx_data, 0);
        chk({nm, ".rx_eop"}, bus.rx_eop, 0);
        chk({nm, ".rx_err"}, bus.rx_err, 0);
    endtask

    vec_t       vecs[7];
    logic [7:0] exp_b[64];

    initial begin
        bus.dp   = 1'b1;
        bus.dn   = 1'b0;
        abort_tx = 1'b0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #2 chk_reset_vals("reset");
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        vecs[0] = '{128'hA5, 8, 1'b1, 1, 1, 0};
        vecs[1] = '{128'h00FFFF, 24, 1'b1, 3, 1, 0};
        vecs[2] = '{128'h7F, 7, 1'b0, 0, 0, 1};
        vecs[3] = '{128'h2D, 8, 1'b1, 1, 1, 0};
        vecs[4] = '{128'hABC, 12, 1'b1, 1, 1, 1};
        vecs[5] = '{128'h7EFE, 16, 1'b1, 2, 1, 0};
        vecs[6] = '{128'h3CF00FC3, 32, 1'b1, 4, 1, 0};
        for (int k = 0; k < 7; k++)
            run_vec(vecs[k], $sformatf("vec%0d", k));

        // 64-byte random payload with jitter and skew
        clear_mon();
        tx_q.delete();
        for (int i = 0; i < 64; i++) begin
            exp_b[i] = 8'($urandom);
            for (int j = 0; j < 8; j++) tx_q.push_back(exp_b[i][j]);
        end
        send_pkt(1'b1);
        repeat (20) @(negedge clk);
        chk("rand.nbytes", got_q.size(), 64);
        for (int i = 0; i < 64 && i < got_q.size(); i++)
            chk($sformatf("rand.byte%0d", i), got_q[i], exp_b[i]);
        chk("rand.eop", n_eop, 1);
        chk("rand.err", n_err, 0);

        // Reset while the third byte is on the wire
        clear_mon();
        tx_q.delete();
        for (int i = 0; i < 5; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            for (int j = 0; j < 8; j++) tx_q.push_back(b[j]);
        end
        fork
            send_pkt(1'b1);
            begin
                int k;
                k = 0;
                while (got_q.size() < 2 && k < 2000) begin
                    @(negedge clk);
                    k++;
                end
                chk("midrst.wait_byte2", k < 2000, 1);
                repeat (12) @(negedge clk);
                #3;
                rst_n    = 1'b0;
                abort_tx = 1'b1;
                #1 chk_reset_vals("midrst");
            end
        join
        bus.dp = 1'b1;
        bus.dn = 1'b0;
        repeat (5) @(negedge clk);
        rst_n    = 1'b1;
        abort_tx = 1'b0;
        repeat (20) @(negedge clk);
        run_vec('{128'h100069, 24, 1'b1, 3, 1, 0}, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
